// File: rtl/capt_drain.sv
// Capture buffer that fills on the counter's capture strobe and drains over a
// valid/ready stream once the counter reports full (or a drain is forced).
module capt_drain #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 6
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [1:0]        op,
    input  logic              capture,
    input  logic [DATA_W-1:0] din,
    input  logic              full,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [2:0]        level,
    output logic              busy,
    output logic              ovf,
    output logic              sync_err,
    output logic [1:0]        dbg_state
);

    // Stream handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both 1; while out_ready is 0 the offered word stays put.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] LVL_MAX = 3'(DEPTH);

    state_t            state, state_nxt;
    logic [2:0]        level_q;
    logic [2:0]        rd_ptr;
    logic [DATA_W-1:0] buf_q [DEPTH];
    logic              ovf_q;
    logic              sync_q;

    logic       op_arm, op_drain, op_clear;
    logic       lvl_full, cap_ok, is_last, xfer;
    logic [2:0] lvl_capt;

    assign op_arm   = (op == 2'b01);
    assign op_drain = (op == 2'b10);
    assign op_clear = (op == 2'b11);
    assign lvl_full = (level_q == LVL_MAX);
    assign cap_ok   = (state == CAPT) && capture && !lvl_full;
    assign lvl_capt = cap_ok ? level_q + 3'd1 : level_q;
    assign is_last  = (rd_ptr == level_q - 3'd1);
    assign xfer     = (state == DRAIN) && out_ready;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (op_clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (op_arm) state_nxt = CAPT;
                // A drain of nothing has nothing to offer, so fall back to idle.
                CAPT:  if (full || lvl_full || op_drain)
                           state_nxt = (lvl_capt == 3'd0) ? IDLE : DRAIN;
                DRAIN: if (xfer && is_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            rd_ptr  <= '0;
            ovf_q   <= 1'b0;
            sync_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else if (op_clear) begin
            level_q <= '0;
            rd_ptr  <= '0;
            ovf_q   <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_arm) level_q <= '0;
                    rd_ptr <= '0;
                end
                CAPT: begin
                    if (cap_ok) buf_q[level_q] <= din;
                    level_q <= lvl_capt;
                    rd_ptr  <= '0;
                    if (capture && lvl_full) ovf_q <= 1'b1;
                    // Counter and buffer step on the same edge, so they must agree.
                    if (full != lvl_full) sync_q <= 1'b1;
                end
                DRAIN: begin
                    if (xfer) begin
                        if (is_last) begin
                            rd_ptr  <= '0;
                            level_q <= '0;
                        end else begin
                            rd_ptr <= rd_ptr + 3'd1;
                        end
                    end
                end
                default: begin
                    level_q <= '0;
                    rd_ptr  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        if (state == DRAIN) begin
            out_valid = 1'b1;
            out_data  = buf_q[rd_ptr];
            out_last  = is_last;
        end
    end

    assign level     = level_q;
    assign busy      = (state != IDLE);
    assign ovf       = ovf_q;
    assign sync_err  = sync_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_capt_drain.sv
// Bench for capt_drain: drives fill/drain sequences and checks drained words
// against the words it captured, plus level, flags and cycle counts.
module tb_capt_drain;

    logic       clock;
    logic       rst_n;
    logic [1:0] op;
    logic       capture;
    logic [7:0] din;
    logic       full;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [2:0] level;
    logic       busy;
    logic       ovf;
    logic       sync_err;
    logic [1:0] dbg_state;

    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_fail;
    int         n_xfer;
    logic       prev_hold;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [3:0] ready_pat;
    int         cyc;

    localparam logic [1:0] NOP = 2'b00, ARM = 2'b01, DRN = 2'b10, CLR = 2'b11;

    capt_drain #(.DATA_W(8), .DEPTH(6)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .op        (op),
        .capture   (capture),
        .din       (din),
        .full      (full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .level     (level),
        .busy      (busy),
        .ovf       (ovf),
        .sync_err  (sync_err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step(input logic [1:0] o, input logic c, input logic [7:0] d, input logic f);
        op      = o;
        capture = c;
        din     = d;
        full    = f;
        @(posedge clock);
        #1;
        op      = NOP;
        capture = 1'b0;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + 8'(i);
            step(NOP, 1'b1, d, 1'b0);
            exp_q.push_back(d);
        end
    endtask

    task automatic run_drain(input bit toggle, output int ncyc);
        ncyc = 0;
        while (busy === 1'b1 && ncyc < 64) begin
            out_ready = toggle ? ready_pat[ncyc % 4] : 1'b1;
            @(posedge clock);
            #1;
            ncyc++;
        end
        out_ready = 1'b1;
        check("drain_finished", {31'd0, busy}, 32'd0);
    endtask

    // scoreboard: compare every transferred word, and hold stability while stalled
    always @(negedge clock) begin
        if (out_valid === 1'b1) begin
            if (prev_hold) begin
                check("hold_data", {24'd0, out_data}, {24'd0, prev_data});
                check("hold_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    check("out_last", {31'd0, out_last}, {31'd0, exp_q.size() == 1});
                    check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                end
                n_xfer++;
            end
        end
        prev_hold = (out_valid === 1'b1) && (out_ready !== 1'b1);
        prev_data = out_data;
        prev_last = out_last;
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_xfer    = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        ready_pat = 4'b1001;
        rst_n     = 1'b0;
        op        = NOP;
        capture   = 1'b0;
        din       = '0;
        full      = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_level", {29'd0, level}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_flags", {30'd0, ovf, sync_err}, 0);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        // full 6-word fill, drain with ready held high
        step(ARM, 1'b0, 8'h00, 1'b0);
        check("arm_state", {30'd0, dbg_state}, 1);
        fill(6, 8'h11);
        check("fill_level", {29'd0, level}, 6);
        step(NOP, 1'b0, 8'h00, 1'b1);
        full = 1'b0;
        check("drain_valid", {31'd0, out_valid}, 1);
        check("drain_level", {29'd0, level}, 6);
        n_xfer = 0;
        run_drain(1'b0, cyc);
        check("drain_cycles", cyc, 6);
        check("drain_xfers", n_xfer, 6);
        check("t1_level", {29'd0, level}, 0);
        check("t1_sync", {31'd0, sync_err}, 0);
        check("t1_ovf", {31'd0, ovf}, 0);
        check("t1_valid_after", {31'd0, out_valid}, 0);

        // same fill, ready pattern 1,0,0,1
        step(ARM, 1'b0, 8'h00, 1'b0);
        fill(6, 8'h11);
        step(NOP, 1'b0, 8'h00, 1'b1);
        full = 1'b0;
        n_xfer = 0;
        run_drain(1'b1, cyc);
        check("toggle_cycles", cyc, 12);
        check("toggle_xfers", n_xfer, 6);
        check("toggle_empty", exp_q.size(), 0);

        // forced drain of 3 words, capture during drain ignored
        step(ARM, 1'b0, 8'h00, 1'b0);
        fill(3, 8'hA0);
        step(DRN, 1'b0, 8'h00, 1'b0);
        check("force_state", {30'd0, dbg_state}, 2);
        out_ready = 1'b0;
        step(NOP, 1'b1, 8'hFF, 1'b0);
        check("force_level", {29'd0, level}, 3);
        n_xfer = 0;
        run_drain(1'b0, cyc);
        check("force_xfers", n_xfer, 3);
        check("force_ovf", {31'd0, ovf}, 0);

        // full arrives early: sync error, sticky across ARM until CLEAR
        step(ARM, 1'b0, 8'h00, 1'b0);
        fill(2, 8'hB0);
        check("early_sync_pre", {31'd0, sync_err}, 0);
        step(NOP, 1'b0, 8'h00, 1'b1);
        full = 1'b0;
        check("early_sync", {31'd0, sync_err}, 1);
        n_xfer = 0;
        run_drain(1'b0, cyc);
        check("early_xfers", n_xfer, 2);
        check("early_sticky", {31'd0, sync_err}, 1);
        step(ARM, 1'b0, 8'h00, 1'b0);
        check("early_after_arm", {31'd0, sync_err}, 1);
        step(CLR, 1'b0, 8'h00, 1'b0);
        check("early_clear", {31'd0, sync_err}, 0);
        check("early_clear_busy", {31'd0, busy}, 0);

        // overflow: capture while already holding 6 words
        step(ARM, 1'b0, 8'h00, 1'b0);
        fill(6, 8'hD0);
        step(NOP, 1'b1, 8'hEE, 1'b1);
        full = 1'b0;
        check("ovf_set", {31'd0, ovf}, 1);
        check("ovf_level", {29'd0, level}, 6);
        n_xfer = 0;
        run_drain(1'b0, cyc);
        check("ovf_xfers", n_xfer, 6);
        check("ovf_sticky", {31'd0, ovf}, 1);
        step(CLR, 1'b0, 8'h00, 1'b0);
        check("ovf_clear", {31'd0, ovf}, 0);

        // CLEAR during the 3rd drain word
        step(ARM, 1'b0, 8'h00, 1'b0);
        fill(6, 8'hC0);
        step(NOP, 1'b0, 8'h00, 1'b1);
        full = 1'b0;
        step(NOP, 1'b0, 8'h00, 1'b0);
        step(NOP, 1'b0, 8'h00, 1'b0);
        check("abort_word", {24'd0, out_data}, 32'hC2);
        out_ready = 1'b0;
        step(CLR, 1'b0, 8'h00, 1'b0);
        out_ready = 1'b1;
        check("abort_valid", {31'd0, out_valid}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_level", {29'd0, level}, 0);
        exp_q.delete();
        step(NOP, 1'b1, 8'h55, 1'b0);
        check("idle_capture", {29'd0, level}, 0);
        step(ARM, 1'b0, 8'h00, 1'b0);
        step(DRN, 1'b0, 8'h00, 1'b0);
        check("empty_force_busy", {31'd0, busy}, 0);
        check("empty_force_valid", {31'd0, out_valid}, 0);

        // async reset in the middle of a drain
        step(ARM, 1'b0, 8'h00, 1'b0);
        fill(3, 8'hE0);
        out_ready = 1'b0;
        step(DRN, 1'b0, 8'h00, 1'b0);
        step(NOP, 1'b0, 8'h00, 1'b0);
        check("mid_valid_pre", {31'd0, out_valid}, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 0);
        check("mid_rst_data", {24'd0, out_data}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_level", {29'd0, level}, 0);
        check("mid_rst_state", {30'd0, dbg_state}, 0);
        exp_q.delete();
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
